// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, constants and types for the instruction fetch stage
package inst_fetch_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_DATA_W-1:0] inst_data_t;
  localparam inst_data_t ZERO_WORD = '0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic       valid;
    inst_addr_t target;
  } pend_t;
endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, bubble and flush
module if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_i,
  input  logic       flush_i,
  input  logic       stall_if_i,
  input  logic       stall_id_i,
  input  inst_addr_t pc_i,
  input  inst_data_t inst_i,
  output inst_addr_t id_pc_o,
  output inst_data_t id_inst_o
);
  inst_addr_t pc_q, pc_d;
  inst_data_t inst_q, inst_d;
  logic zero, hold;
  // flush or a disabled ROM yields zeros; ID stall holds; IF-only stall inserts a bubble
  always_comb begin
    zero   = flush_i | !ce_i | (stall_if_i & !stall_id_i);
    hold   = !flush_i & ce_i & stall_id_i;
    pc_d   = hold ? pc_q : zero ? '0 : pc_i;
    inst_d = hold ? inst_q : zero ? ZERO_WORD : inst_i;
  end
  // register update
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      inst_q <= ZERO_WORD;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end
  assign id_pc_o   = pc_q;
  assign id_inst_o = inst_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, ROM enable and pending-branch logic feeding the IF/ID register
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int         PC_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_if_i,
  input  logic       stall_id_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  input  logic       flush_i,
  input  inst_addr_t flush_pc_i,
  output logic       rom_ce_o,
  output inst_addr_t rom_addr_o,
  input  inst_data_t rom_inst_i,
  output inst_addr_t id_pc_o,
  output inst_data_t id_inst_o,
  output logic       misalign_o
);
  logic       ce_q;
  inst_addr_t pc_q, pc_d, tgt;
  pend_t      pend_q, pend_d;
  logic       mis_q, mis_d, stall, redir;
  // next-PC priority: flush, stall (latch branch), pending/branch redirect, sequential
  always_comb begin
    stall  = stall_if_i | stall_id_i;
    redir  = flush_i | (!stall & (pend_q.valid | branch_flag_i));
    tgt    = flush_i ? flush_pc_i : branch_flag_i ? branch_target_i : pend_q.target;
    pc_d   = !ce_q ? pc_q : redir ? tgt : stall ? pc_q : pc_q + inst_addr_t'(PC_STEP);
    pend_d = !ce_q ? pend_q : flush_i ? '0 :
             stall ? (branch_flag_i ? {1'b1, branch_target_i} : pend_q) : '0;
    mis_d  = (ce_q & redir) ? |tgt[1:0] : mis_q;
  end
  // PC, chip enable, pending branch and misalignment state
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q   <= CHIP_DISABLE;
      pc_q   <= RESET_PC;
      pend_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      ce_q   <= CHIP_ENABLE;
      pc_q   <= pc_d;
      pend_q <= pend_d;
      mis_q  <= mis_d;
    end
  end
  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign misalign_o = mis_q;
  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_q),
    .flush_i    (flush_i),
    .stall_if_i (stall),
    .stall_id_i (stall_id_i),
    .pc_i       (pc_q),
    .inst_i     (rom_inst_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed table-driven check of the instruction fetch stage
module tb_inst_fetch;
  logic        clk = 0, rst = 1;
  logic        stall_if = 0, stall_id = 0, br = 0, flush = 0;
  logic [31:0] br_t = 0, flush_pc = 0;
  logic        rom_ce, mis;
  logic [31:0] rom_addr, rom_inst, id_pc, id_inst;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0) ? 32'h3401_1100 : (a ^ 32'hDEAD_0000);
  endfunction
  assign rom_inst = rom(rom_addr);

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall_if_i(stall_if), .stall_id_i(stall_id),
    .branch_flag_i(br), .branch_target_i(br_t), .flush_i(flush), .flush_pc_i(flush_pc),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .misalign_o(mis)
  );

  always @(posedge clk) if (!rst) assert (!(stall_id && !stall_if)) else $error("illegal stall_id without stall_if");

  typedef struct {
    logic sif, sid, b; logic [31:0] bt; logic f; logic [31:0] fp;
    logic [31:0] addr, ipc, iinst; logic m;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sif, sid, b, input logic [31:0] bt, input logic f, input logic [31:0] fp);
    stall_if = sif; stall_id = sid; br = b; br_t = bt; flush = f; flush_pc = fp;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all(input string tag, input logic ce, input logic [31:0] addr, ipc, iinst, input logic m);
    chk({tag, ".ce"}, 32'(rom_ce), 32'(ce));
    chk({tag, ".addr"}, rom_addr, addr);
    chk({tag, ".id_pc"}, id_pc, ipc);
    chk({tag, ".id_inst"}, id_inst, iinst);
    chk({tag, ".mis"}, 32'(mis), 32'(m));
  endtask

  vec_t v[$];

  initial begin
    v.push_back('{0,0,0,0,0,0, 32'h8, 32'h4, rom(32'h4), 0});
    v.push_back('{0,0,1,32'h40,0,0, 32'h40, 32'h8, rom(32'h8), 0});
    v.push_back('{0,0,0,0,0,0, 32'h44, 32'h40, rom(32'h40), 0});
    v.push_back('{1,0,1,32'h80,0,0, 32'h44, 0, 0, 0});
    v.push_back('{1,0,0,0,0,0, 32'h44, 0, 0, 0});
    v.push_back('{0,0,0,0,0,0, 32'h80, 32'h44, rom(32'h44), 0});
    v.push_back('{0,0,0,0,0,0, 32'h84, 32'h80, rom(32'h80), 0});
    v.push_back('{1,1,0,0,0,0, 32'h84, 32'h80, rom(32'h80), 0});
    v.push_back('{1,0,1,32'h40,0,0, 32'h84, 0, 0, 0});
    v.push_back('{1,0,1,32'h40,1,32'h20, 32'h20, 0, 0, 0});
    v.push_back('{0,0,0,0,0,0, 32'h24, 32'h20, rom(32'h20), 0});
    v.push_back('{1,0,1,32'h100,0,0, 32'h24, 0, 0, 0});
    v.push_back('{0,0,1,32'h200,0,0, 32'h200, 32'h24, rom(32'h24), 0});
    v.push_back('{0,0,0,0,0,0, 32'h204, 32'h200, rom(32'h200), 0});
    v.push_back('{0,0,0,0,1,32'h22, 32'h22, 0, 0, 1});
    v.push_back('{0,0,0,0,0,0, 32'h26, 32'h22, rom(32'h22), 1});
    v.push_back('{0,0,1,32'h30,0,0, 32'h30, 32'h26, rom(32'h26), 0});
    v.push_back('{0,0,0,0,1,32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 0, 0});
    v.push_back('{0,0,0,0,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, rom(32'hFFFF_FFF8), 0});
    v.push_back('{0,0,0,0,0,0, 32'h0, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 0});
    v.push_back('{0,0,0,0,0,0, 32'h4, 32'h0, 32'h3401_1100, 0});

    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("rst%0d", i), 0, 0, 0, 0, 0);
    end
    rst = 0;
    step();
    chk_all("release", 1, 32'h0, 0, 0, 0);
    step();
    chk_all("first_fetch", 1, 32'h4, 32'h0, 32'h3401_1100, 0);

    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].sif, v[i].sid, v[i].b, v[i].bt, v[i].f, v[i].fp);
      step();
      chk_all($sformatf("vec%0d", i), 1, v[i].addr, v[i].ipc, v[i].iinst, v[i].m);
    end

    drive(0,0,0,0,1,32'h21);
    step();
    chk_all("mis_set", 1, 32'h21, 0, 0, 1);
    drive(1,0,1,32'h300,0,0);
    step();
    chk_all("pend_before_rst", 1, 32'h21, 0, 0, 1);
    drive(0,0,0,0,0,0);
    rst = 1;
    step();
    chk_all("mid_pend_rst", 0, 0, 0, 0, 0);
    rst = 0;
    step();
    chk_all("mid_pend_release", 1, 0, 0, 0, 0);
    step();
    chk_all("pend_dropped", 1, 32'h4, 32'h0, 32'h3401_1100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
